cnn_layer_seq: RTL and testbench

- Top-level sequencer for the CNN accelerator. On host `ready` it runs layer 0 (conv+ReLU), then layer 1 (2x2 max-pool), and drives `busy` for the whole run.
- Owns the single shared memory bus and forwards the active layer's bus signals to the chip-level ports.
- Per-layer watchdog flags hung layers on `error`.

---
 rtl/cnn_pkg.sv | 37 +++
 rtl/cnn_bus_mux.sv | 60 ++++++
 rtl/cnn_layer_seq.sv | 144 ++++++++++++++
 tb/tb_cnn_layer_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator layer sequencer.
package cnn_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned SEL_W  = 3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START_L0 = 3'd1,
        ST_RUN_L0   = 3'd2,
        ST_START_L1 = 3'd3,
        ST_RUN_L1   = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    // Which layer currently owns the shared memory bus
    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_L0   = 2'd1,
        BUS_L1   = 2'd2
    } bus_sel_e;

    // Host-visible phase codes
    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_L0   = 2'd1;
    localparam logic [1:0] PHASE_L1   = 2'd2;
    localparam logic [1:0] PHASE_END  = 2'd3;

    // Memory-select codes used by the layers
    localparam logic [SEL_W-1:0] CSEL_NONE = 3'd0;
    localparam logic [SEL_W-1:0] CSEL_L0   = 3'd1;
    localparam logic [SEL_W-1:0] CSEL_L1   = 3'd3;

endpackage

// File: rtl/cnn_bus_mux.sv
// Combinational 2:1 memory-bus selector; drives an all-zero idle bus when
// neither layer owns it.
module cnn_bus_mux
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_W = cnn_pkg::ADDR_W,
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned SEL_W  = cnn_pkg::SEL_W
) (
    input  bus_sel_e          sel_i,
    input  logic              l0_cwr_i,
    input  logic              l0_crd_i,
    input  logic [ADDR_W-1:0] l0_caddr_wr_i,
    input  logic [ADDR_W-1:0] l0_caddr_rd_i,
    input  logic [DATA_W-1:0] l0_cdata_wr_i,
    input  logic [SEL_W-1:0]  l0_csel_i,
    input  logic              l1_cwr_i,
    input  logic              l1_crd_i,
    input  logic [ADDR_W-1:0] l1_caddr_wr_i,
    input  logic [ADDR_W-1:0] l1_caddr_rd_i,
    input  logic [DATA_W-1:0] l1_cdata_wr_i,
    input  logic [SEL_W-1:0]  l1_csel_i,
    output logic              cwr_o,
    output logic              crd_o,
    output logic [ADDR_W-1:0] caddr_wr_o,
    output logic [ADDR_W-1:0] caddr_rd_o,
    output logic [DATA_W-1:0] cdata_wr_o,
    output logic [SEL_W-1:0]  csel_o
);

    // Forward the owning layer's bus, otherwise hold everything at zero
    always_comb begin
        cwr_o      = 1'b0;
        crd_o      = 1'b0;
        caddr_wr_o = '0;
        caddr_rd_o = '0;
        cdata_wr_o = '0;
        csel_o     = '0;
        case (sel_i)
            BUS_L0: begin
                cwr_o      = l0_cwr_i;
                crd_o      = l0_crd_i;
                caddr_wr_o = l0_caddr_wr_i;
                caddr_rd_o = l0_caddr_rd_i;
                cdata_wr_o = l0_cdata_wr_i;
                csel_o     = l0_csel_i;
            end
            BUS_L1: begin
                cwr_o      = l1_cwr_i;
                crd_o      = l1_crd_i;
                caddr_wr_o = l1_caddr_wr_i;
                caddr_rd_o = l1_caddr_rd_i;
                cdata_wr_o = l1_cdata_wr_i;
                csel_o     = l1_csel_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// Top-level CNN layer sequencer: runs conv layer 0 then pool layer 1 on a
// host request, owns the shared memory bus and watches each layer for hangs.
module cnn_layer_seq
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_W         = cnn_pkg::ADDR_W,
    parameter int unsigned DATA_W         = cnn_pkg::DATA_W,
    parameter int unsigned SEL_W          = cnn_pkg::SEL_W,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic              error,
    output logic [1:0]        phase,
    output logic              l0_start,
    output logic              l1_start,
    input  logic              l0_finished,
    input  logic              l1_finished,
    input  logic              l0_cwr,
    input  logic              l0_crd,
    input  logic [ADDR_W-1:0] l0_caddr_wr,
    input  logic [ADDR_W-1:0] l0_caddr_rd,
    input  logic [DATA_W-1:0] l0_cdata_wr,
    input  logic [SEL_W-1:0]  l0_csel,
    input  logic              l1_cwr,
    input  logic              l1_crd,
    input  logic [ADDR_W-1:0] l1_caddr_wr,
    input  logic [ADDR_W-1:0] l1_caddr_rd,
    input  logic [DATA_W-1:0] l1_cdata_wr,
    input  logic [SEL_W-1:0]  l1_csel,
    output logic              cwr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [SEL_W-1:0]  csel
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    bus_sel_e        bus_sel;

    // State and watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Next state, watchdog update and state-decoded outputs
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        busy     = 1'b0;
        error    = 1'b0;
        phase    = PHASE_IDLE;
        l0_start = 1'b0;
        l1_start = 1'b0;
        bus_sel  = BUS_NONE;
        case (state_q)
            ST_IDLE: begin
                if (ready) state_d = ST_START_L0;
            end
            ST_START_L0: begin
                busy     = 1'b1;
                phase    = PHASE_L0;
                l0_start = 1'b1;
                bus_sel  = BUS_L0;
                wd_d     = '0;
                state_d  = ST_RUN_L0;
            end
            ST_RUN_L0: begin
                busy    = 1'b1;
                phase   = PHASE_L0;
                bus_sel = BUS_L0;
                // completion has priority over an expiring watchdog
                if (l0_finished)         state_d = ST_START_L1;
                else if (wd_q == WD_LAST) state_d = ST_ERR;
                else                      wd_d    = wd_q + WD_W'(1);
            end
            ST_START_L1: begin
                busy     = 1'b1;
                phase    = PHASE_L1;
                l1_start = 1'b1;
                bus_sel  = BUS_L1;
                wd_d     = '0;
                state_d  = ST_RUN_L1;
            end
            ST_RUN_L1: begin
                busy    = 1'b1;
                phase   = PHASE_L1;
                bus_sel = BUS_L1;
                if (l1_finished)         state_d = ST_DONE;
                else if (wd_q == WD_LAST) state_d = ST_ERR;
                else                      wd_d    = wd_q + WD_W'(1);
            end
            ST_DONE: begin
                phase   = PHASE_END;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                phase = PHASE_END;
                error = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    cnn_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_bus_mux (
        .sel_i         (bus_sel),
        .l0_cwr_i      (l0_cwr),
        .l0_crd_i      (l0_crd),
        .l0_caddr_wr_i (l0_caddr_wr),
        .l0_caddr_rd_i (l0_caddr_rd),
        .l0_cdata_wr_i (l0_cdata_wr),
        .l0_csel_i     (l0_csel),
        .l1_cwr_i      (l1_cwr),
        .l1_crd_i      (l1_crd),
        .l1_caddr_wr_i (l1_caddr_wr),
        .l1_caddr_rd_i (l1_caddr_rd),
        .l1_cdata_wr_i (l1_cdata_wr),
        .l1_csel_i     (l1_csel),
        .cwr_o         (cwr),
        .crd_o         (crd),
        .caddr_wr_o    (caddr_wr),
        .caddr_rd_o    (caddr_rd),
        .cdata_wr_o    (cdata_wr),
        .csel_o        (csel)
    );

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed self-checking bench for the CNN layer sequencer.
module tb_cnn_layer_seq;
    import cnn_pkg::*;

    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              reset, ready;
    logic              busy, error, l0_start, l1_start;
    logic [1:0]        phase;
    logic              l0_finished, l1_finished;
    logic              l0_cwr, l0_crd, l1_cwr, l1_crd;
    logic [ADDR_W-1:0] l0_caddr_wr, l0_caddr_rd, l1_caddr_wr, l1_caddr_rd;
    logic [DATA_W-1:0] l0_cdata_wr, l1_cdata_wr;
    logic [SEL_W-1:0]  l0_csel, l1_csel;
    logic              cwr, crd;
    logic [ADDR_W-1:0] caddr_wr, caddr_rd;
    logic [DATA_W-1:0] cdata_wr;
    logic [SEL_W-1:0]  csel;

    int unsigned chk_cnt = 0;
    int unsigned pass_cnt = 0;

    always #5 clk = ~clk;

    cnn_layer_seq #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .SEL_W          (SEL_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .busy        (busy),
        .error       (error),
        .phase       (phase),
        .l0_start    (l0_start),
        .l1_start    (l1_start),
        .l0_finished (l0_finished),
        .l1_finished (l1_finished),
        .l0_cwr      (l0_cwr),
        .l0_crd      (l0_crd),
        .l0_caddr_wr (l0_caddr_wr),
        .l0_caddr_rd (l0_caddr_rd),
        .l0_cdata_wr (l0_cdata_wr),
        .l0_csel     (l0_csel),
        .l1_cwr      (l1_cwr),
        .l1_crd      (l1_crd),
        .l1_caddr_wr (l1_caddr_wr),
        .l1_caddr_rd (l1_caddr_rd),
        .l1_cdata_wr (l1_cdata_wr),
        .l1_csel     (l1_csel),
        .cwr         (cwr),
        .crd         (crd),
        .caddr_wr    (caddr_wr),
        .caddr_rd    (caddr_rd),
        .cdata_wr    (cdata_wr),
        .csel        (csel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_busses();
        l0_cwr = 1'b1; l0_crd = 1'b1; l0_caddr_wr = 12'h111; l0_caddr_rd = 12'h123;
        l0_cdata_wr = 20'h12345; l0_csel = CSEL_L0;
        l1_cwr = 1'b1; l1_crd = 1'b0; l1_caddr_wr = 12'h3FF; l1_caddr_rd = 12'hABC;
        l1_cdata_wr = 20'h80000; l1_csel = CSEL_L1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ready = 1'b0; l0_finished = 1'b0; l1_finished = 1'b0;
        drive_busses();
        repeat (3) tick();
        chk_cnt++;
        if ({busy, error, l0_start, l1_start} !== 4'b0000)
            $display("FAIL reset_ctrl: busy/error/l0s/l1s=%b want 0000", {busy, error, l0_start, l1_start});
        else pass_cnt++;
        chk_cnt++;
        if (phase !== PHASE_IDLE) $display("FAIL reset_phase: got %0d want 0", phase);
        else pass_cnt++;
        chk_cnt++;
        if ({cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel} !== '0)
            $display("FAIL reset_bus: cwr=%b crd=%b aw=%h ar=%h d=%h s=%h want all 0",
                     cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++;
        if ({busy, phase, cwr, crd, csel} !== '0)
            $display("FAIL idle_after_reset: busy=%b phase=%0d cwr=%b crd=%b csel=%0d want 0",
                     busy, phase, cwr, crd, csel);
        else pass_cnt++;
    endtask

    task automatic test_nominal();
        drive_busses();
        ready = 1'b1;
        tick();                                 // START_L0
        ready = 1'b0;
        chk_cnt++;
        if ({busy, l0_start, l1_start, phase} !== {1'b1, 1'b1, 1'b0, PHASE_L0})
            $display("FAIL start_l0: busy=%b l0s=%b l1s=%b phase=%0d want 1 1 0 1", busy, l0_start, l1_start, phase);
        else pass_cnt++;
        tick();                                 // RUN_L0
        chk_cnt++;
        if ({busy, l0_start, phase} !== {1'b1, 1'b0, PHASE_L0})
            $display("FAIL run_l0: busy=%b l0s=%b phase=%0d want 1 0 1", busy, l0_start, phase);
        else pass_cnt++;
        l0_caddr_rd = 12'h456; l1_caddr_rd = 12'hABC;
        #1;
        chk_cnt++;
        if ({caddr_rd, crd, cwr, caddr_wr, cdata_wr, csel} !== {12'h456, 1'b1, 1'b1, 12'h111, 20'h12345, CSEL_L0})
            $display("FAIL mux_l0: ar=%h crd=%b cwr=%b aw=%h d=%h s=%0d want 456 1 1 111 12345 1",
                     caddr_rd, crd, cwr, caddr_wr, cdata_wr, csel);
        else pass_cnt++;
        l0_caddr_rd = 12'h123;
        #1;
        chk_cnt++;
        if (caddr_rd !== 12'h123) $display("FAIL mux_l0_comb: ar=%h want 123", caddr_rd);
        else pass_cnt++;
        l1_finished = 1'b1;
        tick();
        l1_finished = 1'b0;
        chk_cnt++;
        if ({phase, l1_start, busy} !== {PHASE_L0, 1'b0, 1'b1})
            $display("FAIL stray_l1_fin: phase=%0d l1s=%b busy=%b want 1 0 1", phase, l1_start, busy);
        else pass_cnt++;
        repeat (3) tick();
        l0_finished = 1'b1;
        tick();                                 // START_L1
        l0_finished = 1'b0;
        chk_cnt++;
        if ({busy, l1_start, l0_start, phase, error} !== {1'b1, 1'b1, 1'b0, PHASE_L1, 1'b0})
            $display("FAIL start_l1: busy=%b l1s=%b l0s=%b phase=%0d err=%b want 1 1 0 2 0",
                     busy, l1_start, l0_start, phase, error);
        else pass_cnt++;
        chk_cnt++;
        if (caddr_rd !== 12'hABC) $display("FAIL mux_start_l1: ar=%h want abc", caddr_rd);
        else pass_cnt++;
        tick();                                 // RUN_L1
        chk_cnt++;
        if (l1_start !== 1'b0) $display("FAIL l1_start_pulse: got %b want 0", l1_start);
        else pass_cnt++;
        chk_cnt++;
        if ({cwr, crd, caddr_wr, cdata_wr, csel} !== {1'b1, 1'b0, 12'h3FF, 20'h80000, CSEL_L1})
            $display("FAIL mux_l1: cwr=%b crd=%b aw=%h d=%h s=%0d want 1 0 3ff 80000 3",
                     cwr, crd, caddr_wr, cdata_wr, csel);
        else pass_cnt++;
        l1_finished = 1'b1;
        tick();                                 // DONE
        l1_finished = 1'b0;
        chk_cnt++;
        if ({busy, phase, error} !== {1'b0, PHASE_END, 1'b0})
            $display("FAIL done: busy=%b phase=%0d err=%b want 0 3 0", busy, phase, error);
        else pass_cnt++;
        chk_cnt++;
        if ({cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel} !== '0)
            $display("FAIL done_bus: cwr=%b aw=%h ar=%h want 0", cwr, caddr_wr, caddr_rd);
        else pass_cnt++;
        tick();                                 // IDLE
        chk_cnt++;
        if ({busy, phase} !== {1'b0, PHASE_IDLE})
            $display("FAIL back_idle: busy=%b phase=%0d want 0 0", busy, phase);
        else pass_cnt++;
    endtask

    task automatic test_finish_at_timeout();
        ready = 1'b1;
        tick();                                 // START_L0
        ready = 1'b0;
        tick();                                 // RUN_L0, watchdog 0
        repeat (TO - 1) tick();                 // RUN_L0, watchdog at last count
        chk_cnt++;
        if ({phase, error} !== {PHASE_L0, 1'b0})
            $display("FAIL wd_last_cycle: phase=%0d err=%b want 1 0", phase, error);
        else pass_cnt++;
        l0_finished = 1'b1;
        tick();
        l0_finished = 1'b0;
        chk_cnt++;
        if ({l1_start, error, phase} !== {1'b1, 1'b0, PHASE_L1})
            $display("FAIL finish_wins: l1s=%b err=%b phase=%0d want 1 0 2", l1_start, error, phase);
        else pass_cnt++;
        tick();                                 // RUN_L1
        l1_finished = 1'b1;
        tick();                                 // DONE
        l1_finished = 1'b0;
        tick();                                 // IDLE
        chk_cnt++;
        if ({busy, error, phase} !== {1'b0, 1'b0, PHASE_IDLE})
            $display("FAIL after_finish_wins: busy=%b err=%b phase=%0d want 0 0 0", busy, error, phase);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int unsigned low_cnt;
        ready = 1'b1;
        tick();                                 // START_L0
        tick();                                 // RUN_L0
        l0_finished = 1'b1;
        tick();                                 // START_L1
        l0_finished = 1'b0;
        tick();                                 // RUN_L1
        l1_finished = 1'b1;
        tick();                                 // DONE
        l1_finished = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) break;
            low_cnt++;
            tick();
        end
        chk_cnt++;
        if (low_cnt !== 2) $display("FAIL b2b_gap: busy-low cycles=%0d want 2", low_cnt);
        else pass_cnt++;
        chk_cnt++;
        if ({l0_start, phase} !== {1'b1, PHASE_L0})
            $display("FAIL b2b_restart: l0s=%b phase=%0d want 1 1", l0_start, phase);
        else pass_cnt++;
        ready = 1'b0;
        tick();                                 // RUN_L0
        l0_finished = 1'b1;
        tick();                                 // START_L1
        l0_finished = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        tick();                                 // RUN_L1 from previous run
        chk_cnt++;
        if ({phase, cwr} !== {PHASE_L1, 1'b1})
            $display("FAIL pre_reset_l1: phase=%0d cwr=%b want 2 1", phase, cwr);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({busy, l1_start, phase, cwr, crd, caddr_wr, cdata_wr, csel} !== '0)
            $display("FAIL async_reset: busy=%b l1s=%b phase=%0d cwr=%b aw=%h d=%h s=%0d want 0",
                     busy, l1_start, phase, cwr, caddr_wr, cdata_wr, csel);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk_cnt++;
        if ({l0_start, busy, phase} !== {1'b1, 1'b1, PHASE_L0})
            $display("FAIL restart_after_reset: l0s=%b busy=%b phase=%0d want 1 1 1", l0_start, busy, phase);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        tick();                                 // RUN_L0, watchdog 0
        repeat (TO - 1) tick();
        chk_cnt++;
        if ({busy, error} !== 2'b10) $display("FAIL before_timeout: busy=%b err=%b want 1 0", busy, error);
        else pass_cnt++;
        tick();                                 // ERR
        chk_cnt++;
        if ({error, busy, phase} !== {1'b1, 1'b0, PHASE_END})
            $display("FAIL timeout: err=%b busy=%b phase=%0d want 1 0 3", error, busy, phase);
        else pass_cnt++;
        chk_cnt++;
        if ({cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel} !== '0)
            $display("FAIL err_bus: cwr=%b crd=%b aw=%h ar=%h want 0", cwr, crd, caddr_wr, caddr_rd);
        else pass_cnt++;
        ready = 1'b1;
        l0_finished = 1'b1;
        tick();
        ready = 1'b0;
        l0_finished = 1'b0;
        repeat (3) tick();
        chk_cnt++;
        if ({error, busy, l0_start, phase} !== {1'b1, 1'b0, 1'b0, PHASE_END})
            $display("FAIL err_sticky: err=%b busy=%b l0s=%b phase=%0d want 1 0 0 3", error, busy, l0_start, phase);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({error, phase} !== 3'b000) $display("FAIL err_clear: err=%b phase=%0d want 0 0", error, phase);
        else pass_cnt++;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_finish_at_timeout();
        test_back_to_back();
        test_reset_mid_run();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
